// File: rtl/next_pc_predictor.sv
// Fetch-stage next-PC generation with a 2-bit bimodal branch history table,
// execute-stage branch resolution, redirect, link write and mispredict statistics.
module next_pc_predictor #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          BHT_DEPTH    = 64,
  parameter logic [1:0]  COUNTER_INIT = 2'b01,
  parameter int          STAT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [31:0]       if_instr,
  output logic [31:0]       pc,
  output logic              if_pred_taken,
  input  logic              ex_valid,
  input  logic [31:0]       ex_pc,
  input  logic [31:0]       ex_instr,
  input  logic [31:0]       ex_rega,
  input  logic [31:0]       ex_regb,
  input  logic              ex_pred_taken,
  output logic              flush,
  output logic              link_we,
  output logic [4:0]        link_reg,
  output logic [31:0]       link_data,
  output logic [STAT_W-1:0] mispredict_count
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  function automatic logic is_cond(input logic [5:0] op);
    return (op == 6'd1) || (op == 6'd4) || (op == 6'd5) || (op == 6'd6) || (op == 6'd7);
  endfunction

  function automatic logic is_jump(input logic [5:0] op);
    return (op == 6'd2) || (op == 6'd3);
  endfunction

  function automatic logic is_rjump(input logic [5:0] op, input logic [5:0] funct);
    return (op == 6'd0) && ((funct == 6'd8) || (funct == 6'd9));
  endfunction

  function automatic logic [31:0] branch_target(input logic [31:0] p, input logic [15:0] imm);
    return p + 32'd4 + {{14{imm[15]}}, imm, 2'b00};
  endfunction

  function automatic logic [31:0] jump_target(input logic [3:0] region, input logic [25:0] idx);
    return {region, idx, 2'b00};
  endfunction

  logic [1:0]       bht [BHT_DEPTH];
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic [1:0]       if_ctr;
  logic [1:0]       ex_ctr;
  logic [1:0]       ex_ctr_next;
  logic [31:0]      fetch_next;
  logic [5:0]       if_op;
  logic [5:0]       ex_op;
  logic             ex_cond;
  logic             ex_rjump;
  logic             ex_taken;
  logic [31:0]      ex_actual_next;
  logic [31:0]      redirect;

  assign if_op  = if_instr[31:26];
  assign ex_op  = ex_instr[31:26];
  assign if_idx = pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign if_ctr = bht[if_idx];
  assign ex_ctr = bht[ex_idx];

  // Fetch prediction: direct jumps always taken, register jumps never.
  always_comb begin
    fetch_next    = pc + 32'd4;
    if_pred_taken = 1'b0;
    if (is_jump(if_op)) begin
      fetch_next    = jump_target(pc[31:28], if_instr[25:0]);
      if_pred_taken = 1'b1;
    end else if (is_cond(if_op) && if_ctr[1]) begin
      fetch_next    = branch_target(pc, if_instr[15:0]);
      if_pred_taken = 1'b1;
    end
  end

  // Signed condition evaluation; a negative value is identified by its sign bit.
  always_comb begin
    ex_taken = 1'b0;
    case (ex_op)
      6'd1:    ex_taken = ex_instr[16] ? ~ex_rega[31] : ex_rega[31];
      6'd4:    ex_taken = (ex_rega == ex_regb);
      6'd5:    ex_taken = (ex_rega != ex_regb);
      6'd6:    ex_taken = ex_rega[31] || (ex_rega == 32'd0);
      6'd7:    ex_taken = ~ex_rega[31] && (ex_rega != 32'd0);
      default: ex_taken = 1'b0;
    endcase
  end

  assign ex_cond  = ex_valid && is_cond(ex_op);
  assign ex_rjump = ex_valid && is_rjump(ex_op, ex_instr[5:0]);

  always_comb begin
    ex_actual_next = ex_pc + 32'd4;
    if (is_jump(ex_op))
      ex_actual_next = jump_target(ex_pc[31:28], ex_instr[25:0]);
    else if (ex_taken)
      ex_actual_next = branch_target(ex_pc, ex_instr[15:0]);
  end

  assign flush    = (ex_cond && (ex_taken != ex_pred_taken)) || ex_rjump;
  assign redirect = ex_rjump ? ex_rega : ex_actual_next;

  always_comb begin
    if (ex_taken)
      ex_ctr_next = (ex_ctr == 2'b11) ? 2'b11 : ex_ctr + 2'd1;
    else
      ex_ctr_next = (ex_ctr == 2'b00) ? 2'b00 : ex_ctr - 2'd1;
  end

  always_comb begin
    link_we   = 1'b0;
    link_reg  = 5'd0;
    link_data = 32'd0;
    if (ex_valid && (ex_op == 6'd3)) begin
      link_we   = 1'b1;
      link_reg  = 5'd31;
      link_data = ex_pc + 32'd4;
    end else if (ex_valid && (ex_op == 6'd0) && (ex_instr[5:0] == 6'd9)) begin
      link_we   = 1'b1;
      link_reg  = ex_instr[15:11];
      link_data = ex_pc + 32'd4;
    end
  end

  // A redirect wins over a stall so the squashed path is never held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pc <= RESET_PC;
    else if (flush)
      pc <= redirect;
    else if (!stall)
      pc <= fetch_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++)
        bht[i] <= COUNTER_INIT;
    end else if (ex_cond) begin
      bht[ex_idx] <= ex_ctr_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      mispredict_count <= '0;
    else if (flush && (mispredict_count != {STAT_W{1'b1}}))
      mispredict_count <= mispredict_count + 1'b1;
  end

endmodule

// File: tb/tb_next_pc_predictor.sv
// Directed bench for next_pc_predictor: fetch sequencing, redirects, BHT training,
// link writes, statistics saturation and asynchronous reset.
module tb_next_pc_predictor;

  logic        clk;
  logic        rst;
  logic        stall;
  logic [31:0] if_instr;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_instr;
  logic [31:0] ex_rega;
  logic [31:0] ex_regb;
  logic        ex_pred_taken;

  logic [31:0] pc, pc_s;
  logic        if_pred_taken, if_pred_taken_s;
  logic        flush, flush_s;
  logic        link_we, link_we_s;
  logic [4:0]  link_reg, link_reg_s;
  logic [31:0] link_data, link_data_s;
  logic [15:0] mispredict_count;
  logic [1:0]  mispredict_count_s;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;
  logic [31:0] exp_q[$];

  next_pc_predictor dut (
    .clk(clk), .rst(rst), .stall(stall), .if_instr(if_instr), .pc(pc),
    .if_pred_taken(if_pred_taken), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_instr(ex_instr), .ex_rega(ex_rega), .ex_regb(ex_regb),
    .ex_pred_taken(ex_pred_taken), .flush(flush), .link_we(link_we),
    .link_reg(link_reg), .link_data(link_data), .mispredict_count(mispredict_count)
  );

  next_pc_predictor #(.STAT_W(2)) dut_s (
    .clk(clk), .rst(rst), .stall(stall), .if_instr(if_instr), .pc(pc_s),
    .if_pred_taken(if_pred_taken_s), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_instr(ex_instr), .ex_rega(ex_rega), .ex_regb(ex_regb),
    .ex_pred_taken(ex_pred_taken), .flush(flush_s), .link_we(link_we_s),
    .link_reg(link_reg_s), .link_data(link_data_s), .mispredict_count(mispredict_count_s)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic jr_to(input logic [31:0] addr);
    ex_valid = 1'b1;
    ex_pc    = 32'h0000_0600;
    ex_instr = 32'h0000_0008;
    ex_rega  = addr;
    tick();
    ex_valid = 1'b0;
    exp_cnt++;
  endtask

  task automatic bht_upd(input logic taken);
    ex_valid      = 1'b1;
    ex_pc         = 32'h0000_0300;
    ex_instr      = 32'h1400_0005;
    ex_rega       = 32'd1;
    ex_regb       = taken ? 32'd2 : 32'd1;
    ex_pred_taken = taken;
    #1;
    check("upd_noflush", {31'd0, flush}, 32'd0);
    tick();
    ex_valid = 1'b0;
  endtask

  task automatic exec_br(input string tag, input logic [31:0] epc, input logic [31:0] instr,
                         input logic [31:0] a, input logic [31:0] b, input logic pred,
                         input logic exp_flush, input logic [31:0] exp_pc);
    ex_valid      = 1'b1;
    ex_pc         = epc;
    ex_instr      = instr;
    ex_rega       = a;
    ex_regb       = b;
    ex_pred_taken = pred;
    #1;
    check({tag, "_flush"}, {31'd0, flush}, {31'd0, exp_flush});
    tick();
    ex_valid = 1'b0;
    if (exp_flush) begin
      exp_cnt++;
      check({tag, "_pc"}, pc, exp_pc);
    end
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; if_instr = 32'd0; ex_valid = 1'b0;
    ex_pc = 32'd0; ex_instr = 32'd0; ex_rega = 32'd0; ex_regb = 32'd0; ex_pred_taken = 1'b0;

    // Reset and straight-line fetch
    #1 rst = 1'b1;
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_cnt", mispredict_count, 32'd0);
    tick(); tick();
    #2 rst = 1'b0;
    check("post_rst_pc", pc, 32'h0);
    check("nop_pred", {31'd0, if_pred_taken}, 32'd0);
    check("nop_flush", {31'd0, flush}, 32'd0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    while (exp_q.size() > 0) begin
      tick();
      check("seq_pc", pc, exp_q.pop_front());
    end
    check("seq_cnt", mispredict_count, 32'd0);

    // BEQ mispredicted not-taken
    exec_br("beq_first", 32'h40, 32'h1000_0003, 32'd5, 32'd5, 1'b0, 1'b1, 32'h50);
    check("beq_cnt", mispredict_count, 32'd1);
    check("beq_cnt_s", mispredict_count_s, 32'd1);

    // Refetch BEQ: now predicted taken; BLTZ resolves as predicted
    jr_to(32'h40);
    check("jr_pc", pc, 32'h40);
    if_instr      = 32'h1000_0003;
    ex_valid      = 1'b1;
    ex_pc         = 32'h80;
    ex_instr      = 32'h0400_0004;
    ex_rega       = 32'hFFFF_FFFF;
    ex_pred_taken = 1'b1;
    #1;
    check("beq_pred", {31'd0, if_pred_taken}, 32'd1);
    check("bltz_noflush", {31'd0, flush}, 32'd0);
    check("bltz_nolink", {31'd0, link_we}, 32'd0);
    tick();
    ex_valid = 1'b0;
    check("beq_pred_pc", pc, 32'h50);
    check("cnt_2", mispredict_count, exp_cnt);

    // JALR under stall
    if_instr = 32'd0;
    stall    = 1'b1;
    ex_valid = 1'b1;
    ex_pc    = 32'h100;
    ex_instr = 32'h0000_2009;
    ex_rega  = 32'h2000;
    #1;
    check("jalr_flush", {31'd0, flush}, 32'd1);
    check("jalr_we", {31'd0, link_we}, 32'd1);
    check("jalr_reg", {27'd0, link_reg}, 32'd4);
    check("jalr_data", link_data, 32'h104);
    tick();
    exp_cnt++;
    ex_valid = 1'b0;
    check("jalr_pc", pc, 32'h2000);
    if_instr = 32'h0800_0040;
    #1;
    check("j_pred", {31'd0, if_pred_taken}, 32'd1);
    check("ex_idle_flush", {31'd0, flush}, 32'd0);
    check("ex_idle_link", {31'd0, link_we}, 32'd0);
    tick();
    check("stall_hold", pc, 32'h2000);
    stall = 1'b0;
    tick();
    check("j_target", pc, 32'h100);
    if_instr = 32'd0;
    ex_valid = 1'b1;
    ex_pc    = 32'h200;
    ex_instr = 32'h0C00_0000;
    #1;
    check("jal_we", {31'd0, link_we}, 32'd1);
    check("jal_reg", {27'd0, link_reg}, 32'd31);
    check("jal_data", link_data, 32'h204);
    check("jal_noflush", {31'd0, flush}, 32'd0);
    ex_valid = 1'b0;

    // Counter training and saturation at one index, pc held by stall
    jr_to(32'h300);
    check("cnt_s_sat", mispredict_count_s, 32'd3);
    stall    = 1'b1;
    if_instr = 32'h1400_0005;
    #1;
    check("ctr_init_pred", {31'd0, if_pred_taken}, 32'd0);
    ex_valid = 1'b1; ex_pc = 32'h300; ex_instr = 32'h1400_0005;
    ex_rega = 32'd1; ex_regb = 32'd2; ex_pred_taken = 1'b1;
    #1;
    check("no_bypass", {31'd0, if_pred_taken}, 32'd0);
    tick();
    ex_valid = 1'b0;
    for (int i = 0; i < 3; i++) bht_upd(1'b1);
    check("sat_hi_pred", {31'd0, if_pred_taken}, 32'd1);
    bht_upd(1'b0);
    check("dec1_pred", {31'd0, if_pred_taken}, 32'd1);
    bht_upd(1'b0);
    check("dec2_pred", {31'd0, if_pred_taken}, 32'd0);
    for (int i = 0; i < 3; i++) bht_upd(1'b0);
    bht_upd(1'b1);
    check("sat_lo_pred", {31'd0, if_pred_taken}, 32'd0);
    bht_upd(1'b1);
    check("retrain_pred", {31'd0, if_pred_taken}, 32'd1);
    check("train_pc", pc, 32'h300);
    check("train_cnt", mispredict_count, exp_cnt);
    stall    = 1'b0;
    if_instr = 32'd0;

    // Condition evaluation and redirect targets
    exec_br("blez_0",    32'h44, 32'h1800_0002, 32'h0,         32'h0, 1'b0, 1'b1, 32'h50);
    exec_br("blez_neg",  32'h44, 32'h1800_0002, 32'hFFFF_FFFE, 32'h0, 1'b1, 1'b0, 32'h0);
    exec_br("blez_pos",  32'h44, 32'h1800_0002, 32'h1,         32'h0, 1'b1, 1'b1, 32'h48);
    exec_br("bgtz_0",    32'h44, 32'h1C00_0002, 32'h0,         32'h0, 1'b1, 1'b1, 32'h48);
    exec_br("bgtz_pos",  32'h44, 32'h1C00_0002, 32'h7,         32'h0, 1'b0, 1'b1, 32'h50);
    exec_br("bgez_min",  32'h44, 32'h0401_0002, 32'h8000_0000, 32'h0, 1'b0, 1'b0, 32'h0);
    exec_br("bgez_0",    32'h44, 32'h0401_0002, 32'h0,         32'h0, 1'b0, 1'b1, 32'h50);
    exec_br("bltz_0",    32'h44, 32'h0400_0002, 32'h0,         32'h0, 1'b1, 1'b1, 32'h48);
    exec_br("bne_eq",    32'h44, 32'h1400_0002, 32'h9,         32'h9, 1'b1, 1'b1, 32'h48);
    exec_br("beq_back",  32'h40, 32'h1000_FFFF, 32'h1,         32'h1, 1'b0, 1'b1, 32'h40);
    exec_br("beq_ne",    32'h40, 32'h1000_FFFF, 32'h1,         32'h2, 1'b0, 1'b0, 32'h0);
    check("cond_cnt", mispredict_count, exp_cnt);
    check("cond_cnt_s", mispredict_count_s, 32'd3);

    // Asynchronous reset in the middle of a pending redirect
    ex_valid = 1'b1; ex_pc = 32'h40; ex_instr = 32'h1000_0003;
    ex_rega = 32'd5; ex_regb = 32'd5; ex_pred_taken = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_pc", pc, 32'h0);
    check("mid_rst_cnt", mispredict_count, 32'd0);
    check("mid_rst_cnt_s", mispredict_count_s, 32'd0);
    tick();
    ex_valid = 1'b0;
    #2 rst = 1'b0;
    check("rst_discard_pc", pc, 32'h0);
    if_instr = 32'h1000_0003;
    #1;
    check("rst_ctr_init", {31'd0, if_pred_taken}, 32'd0);
    tick();
    check("rst_first_fetch", pc, 32'h4);
    check("rst_end_cnt", mispredict_count, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/next_pc_predictor.md
NEXT_PC_PREDICTOR -- requirements
Module: next_pc_predictor

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: fetch address after reset.
REQ-002 SHALL have parameter BHT_DEPTH, default 64, power of 2 from 4 to 1024: number of 2-bit branch history counters.
REQ-003 SHALL have parameter COUNTER_INIT, default 2'b01: counter value after reset.
REQ-004 SHALL have parameter STAT_W, default 16: width of the mispredict statistics counter.
REQ-005 SHALL use one clock and an asynchronous, active-high reset: clk  in  1  clock; rst  in  1  async active-high reset.
REQ-006 SHALL have port stall  in  1: hold fetch PC this cycle.
REQ-007 SHALL have port if_instr  in  32: instruction at current pc.
REQ-008 SHALL have port pc  out  32: current fetch address (registered).
REQ-009 SHALL have port if_pred_taken  out  1: fetch-stage prediction for if_instr.
REQ-010 SHALL have ports ex_valid  in  1, ex_pc  in  32, ex_instr  in  32, ex_rega  in  32, ex_regb  in  32, ex_pred_taken  in  1: execute-stage instruction, operands and the prediction carried down the pipe.
REQ-011 SHALL have port flush  out  1: redirect; younger instructions are squashed.
REQ-012 SHALL have ports link_we  out  1, link_reg  out  5, link_data  out  32: link write for jal/jalr.
REQ-013 SHALL have port mispredict_count  out  STAT_W: saturating count of flushes.

Function
REQ-014 SHALL treat opcodes 1 (BLTZ/BGEZ, rt[0] selects), 4 BEQ, 5 BNE, 6 BLEZ, 7 BGTZ as conditional; 2 J, 3 JAL as direct jump; opcode 0 with funct 8 JR and 9 JALR as register jump.
REQ-015 SHALL use no delay slot: not-taken successor = pc+4, branch target = pc+4+(sign-extended imm16 << 2), jump target = {pc[31:28], instr[25:0], 2'b00}, all modulo 2^32.
REQ-016 SHALL index the BHT with pc[log2(BHT_DEPTH)+1:2] and predict taken when counter[1]=1.
REQ-017 SHALL compute fetch next-PC as: direct jump -> jump target, if_pred_taken=1; conditional with counter[1]=1 -> branch target, if_pred_taken=1; else pc+4, if_pred_taken=0 (JR/JALR predicted not-taken).
REQ-018 SHALL evaluate conditions in execute as signed 32-bit: BEQ a==b, BNE a!=b, BLEZ a<=0, BGTZ a>0, BLTZ a<0, BGEZ a>=0.
REQ-019 SHALL assert flush combinationally when ex_valid and (conditional with actual outcome != ex_pred_taken, or JR/JALR); redirect target = actual successor (branch target, ex_pc+4, or ex_rega).
REQ-020 SHALL load pc with the redirect target on the next edge when flush=1, regardless of stall (flush overrides stall).
REQ-021 SHALL hold pc when stall=1 and flush=0, otherwise load the fetch next-PC.
REQ-022 SHALL, on ex_valid conditional, update the counter indexed by ex_pc: saturating increment if taken, decrement if not; 2'b11 and 2'b00 saturate.
REQ-023 SHALL give same-cycle fetch lookup of an index being updated the old counter value (no bypass).
REQ-024 SHALL drive link_we=1, link_data=ex_pc+4, link_reg=31 for JAL and instr[15:11] for JALR when ex_valid; else link_we=0.
REQ-025 SHALL increment mispredict_count on each flush cycle, saturating at all-ones.
REQ-026 SHALL ignore ex_* inputs (no flush, no update, link_we=0) when ex_valid=0.

Reset
REQ-027 SHALL, while rst=1, force pc=RESET_PC, all counters=COUNTER_INIT, mispredict_count=0, independent of clk.
REQ-028 SHALL, on rst mid-operation, discard any pending redirect; first post-reset fetch is RESET_PC.

Verification
REQ-029 SHALL pass: reset, if_instr=NOPs, no stall -> pc 0x0,0x4,0x8 on successive edges; mispredict_count=0.
REQ-030 SHALL pass: BEQ at 0x40, imm=0x0003, a=b=5, ex_pred_taken=0 -> flush=1, next pc=0x50, counter 01->10, count=1.
REQ-031 SHALL pass: same BEQ at 0x40 fetched again -> if_pred_taken=1, next pc=0x50; BLTZ a=0xFFFFFFFF predicted taken -> no flush.
REQ-032 SHALL pass: JALR ex_pc=0x100, rega=0x2000, rd=4, stall=1 -> flush=1, next pc=0x2000, link_we=1, link_reg=4, link_data=0x104.
REQ-033 SHALL pass: four taken updates then five not-taken to one index -> counter 11 saturates, ends 00; mispredict_count STAT_W=2 saturates at 3.
REQ-034 SHALL pass: rst asserted between clk edges during flush -> pc=RESET_PC immediately, counters=COUNTER_INIT.
